// File: rtl/ep2_cmd_engine_if.sv
// Bus bundle for the EP2 command engine: EP2 OUT buffer port, Wishbone
// master port and the reply (IN buffer) port. The engine uses 'master'.
interface ep2_cmd_engine_if;
    // EP2 OUT buffer
    logic        buf_out_hasdata;
    logic [7:0]  buf_out_q;
    logic [9:0]  buf_out_len;
    logic [8:0]  buf_out_addr;
    logic        buf_out_arm;
    logic        buf_out_arm_ack;
    // Wishbone
    logic [2:0]  wb_adr_o;
    logic [7:0]  wb_dat_o;
    logic [7:0]  wb_dat_i;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    // Reply buffer
    logic [8:0]  usb_in_addr;
    logic [7:0]  usb_in_data;
    logic        usb_in_wren;
    logic        usb_in_ready;
    logic        usb_in_commit;
    logic [9:0]  usb_in_commit_len;
    logic        usb_in_commit_ack;

    modport master (
        input  buf_out_hasdata, buf_out_q, buf_out_len, buf_out_arm_ack,
        output buf_out_addr, buf_out_arm,
        output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i,
        output usb_in_addr, usb_in_data, usb_in_wren, usb_in_commit, usb_in_commit_len,
        input  usb_in_ready, usb_in_commit_ack
    );

    modport slave (
        output buf_out_hasdata, buf_out_q, buf_out_len, buf_out_arm_ack,
        input  buf_out_addr, buf_out_arm,
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o,
        output wb_dat_i, wb_ack_i,
        input  usb_in_addr, usb_in_data, usb_in_wren, usb_in_commit, usb_in_commit_len,
        output usb_in_ready, usb_in_commit_ack
    );
endinterface

// File: rtl/ep2_cmd_engine.sv
// EP2 command engine: walks an OUT packet as (addr, data) pairs, applies
// local register writes, issues Wishbone reads/writes, collects read results
// into a reply packet, commits it and re-arms the OUT buffer.
module ep2_cmd_engine #(
    parameter int RD_LAT     = 4,
    parameter int WB_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    ep2_cmd_engine_if.master  bus,
    output logic [7:0]        reset_ctrl,
    output logic [1:0]        insel,
    output logic [10:0]       isoc_commit_len,
    output logic [15:0]       cmd_count,
    output logic [7:0]        err_count
);
    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_FETCH_A    = 4'd1;
    localparam logic [3:0] S_FETCH_D    = 4'd2;
    localparam logic [3:0] S_EXEC       = 4'd3;
    localparam logic [3:0] S_WB_WAIT    = 4'd4;
    localparam logic [3:0] S_NEXT       = 4'd5;
    localparam logic [3:0] S_REPLY      = 4'd6;
    localparam logic [3:0] S_REPLY_WAIT = 4'd7;
    localparam logic [3:0] S_ARM        = 4'd8;

    localparam logic [7:0]  LAT_LAST = 8'(RD_LAT - 1);
    localparam logic [15:0] TO_LAST  = 16'(WB_TIMEOUT - 1);

    logic [3:0]  state;
    logic [8:0]  pairs;
    logic [8:0]  pair_idx;
    logic [8:0]  next_idx;
    logic [7:0]  lat_cnt;
    logic [15:0] wb_cnt;
    logic [9:0]  reply_cnt;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic        is_read;
    logic        arm_ack_seen;
    logic        wb_done;
    logic [7:0]  reply_byte;
    logic        unused_len_lsb;

    assign next_idx   = pair_idx + 9'd1;
    // A Wishbone cycle ends on the first ack or when the wait budget runs out.
    assign wb_done    = bus.wb_ack_i || (wb_cnt == TO_LAST);
    // Timed-out reads report 0xEE in place of slave data.
    assign reply_byte = bus.wb_ack_i ? bus.wb_dat_i : 8'hEE;
    // A trailing odd byte never forms a pair, so the length LSB is not needed.
    assign unused_len_lsb = bus.buf_out_len[0];

    // Command sequencer: packet walk, Wishbone handshake, reply commit, re-arm.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= S_IDLE;
            bus.wb_stb_o          <= 1'b0;
            bus.wb_we_o           <= 1'b0;
            bus.buf_out_arm       <= 1'b0;
            bus.usb_in_wren       <= 1'b0;
            bus.usb_in_commit     <= 1'b0;
            bus.buf_out_addr      <= '0;
            bus.usb_in_addr       <= '0;
            cmd_count             <= '0;
            err_count             <= '0;
            reset_ctrl            <= 8'hF3;
            insel                 <= 2'b00;
            isoc_commit_len       <= 11'd512;
            pairs                 <= '0;
            pair_idx              <= '0;
            lat_cnt               <= '0;
            wb_cnt                <= '0;
            reply_cnt             <= '0;
            is_read               <= 1'b0;
            arm_ack_seen          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.buf_out_hasdata) begin
                        pairs            <= bus.buf_out_len[9:1];
                        pair_idx         <= '0;
                        reply_cnt        <= '0;
                        lat_cnt          <= '0;
                        bus.buf_out_addr <= '0;
                        if (bus.buf_out_len[9:1] == 9'd0) begin
                            bus.buf_out_arm <= 1'b1;
                            arm_ack_seen    <= 1'b0;
                            state           <= S_ARM;
                        end else begin
                            state <= S_FETCH_A;
                        end
                    end
                end
                S_FETCH_A: begin
                    if (lat_cnt == LAT_LAST) begin
                        cmd_addr         <= bus.buf_out_q;
                        lat_cnt          <= '0;
                        bus.buf_out_addr <= {pair_idx[7:0], 1'b1};
                        state            <= S_FETCH_D;
                    end else begin
                        lat_cnt <= lat_cnt + 8'd1;
                    end
                end
                S_FETCH_D: begin
                    if (lat_cnt == LAT_LAST) begin
                        cmd_data <= bus.buf_out_q;
                        lat_cnt  <= '0;
                        state    <= S_EXEC;
                    end else begin
                        lat_cnt <= lat_cnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    wb_cnt <= '0;
                    state  <= S_NEXT;
                    case (cmd_addr)
                        8'd6: reset_ctrl             <= cmd_data;
                        8'd7: insel                  <= cmd_data[1:0];
                        8'd8: isoc_commit_len[10:8]  <= cmd_data[2:0];
                        8'd9: isoc_commit_len[7:0]   <= cmd_data;
                        8'd5: begin
                            is_read      <= 1'b1;
                            bus.wb_stb_o <= 1'b1;
                            bus.wb_we_o  <= 1'b0;
                            bus.wb_adr_o <= cmd_data[2:0];
                            state        <= S_WB_WAIT;
                        end
                        default: begin
                            is_read      <= 1'b0;
                            bus.wb_stb_o <= 1'b1;
                            bus.wb_we_o  <= 1'b1;
                            bus.wb_adr_o <= cmd_addr[2:0];
                            bus.wb_dat_o <= cmd_data;
                            state        <= S_WB_WAIT;
                        end
                    endcase
                end
                S_WB_WAIT: begin
                    if (wb_done) begin
                        bus.wb_stb_o <= 1'b0;
                        bus.wb_we_o  <= 1'b0;
                        state        <= S_NEXT;
                        if (!bus.wb_ack_i && err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                        if (is_read) begin
                            bus.usb_in_data <= reply_byte;
                            bus.usb_in_addr <= reply_cnt[8:0];
                            bus.usb_in_wren <= 1'b1;
                            reply_cnt       <= reply_cnt + 10'd1;
                        end
                    end else begin
                        wb_cnt <= wb_cnt + 16'd1;
                    end
                end
                S_NEXT: begin
                    bus.usb_in_wren <= 1'b0;
                    cmd_count       <= cmd_count + 16'd1;
                    pair_idx        <= next_idx;
                    if (next_idx < pairs) begin
                        bus.buf_out_addr <= {next_idx[7:0], 1'b0};
                        lat_cnt          <= '0;
                        state            <= S_FETCH_A;
                    end else if (reply_cnt == 10'd0) begin
                        bus.buf_out_arm <= 1'b1;
                        arm_ack_seen    <= 1'b0;
                        state           <= S_ARM;
                    end else begin
                        state <= S_REPLY;
                    end
                end
                S_REPLY: begin
                    if (bus.usb_in_ready) begin
                        bus.usb_in_commit     <= 1'b1;
                        bus.usb_in_commit_len <= reply_cnt;
                        state                 <= S_REPLY_WAIT;
                    end
                end
                S_REPLY_WAIT: begin
                    if (bus.usb_in_commit_ack) begin
                        bus.usb_in_commit <= 1'b0;
                        bus.buf_out_arm   <= 1'b1;
                        arm_ack_seen      <= 1'b0;
                        state             <= S_ARM;
                    end
                end
                S_ARM: begin
                    // Release only after the ack has been seen high and then low.
                    if (bus.buf_out_arm_ack) begin
                        arm_ack_seen <= 1'b1;
                    end else if (arm_ack_seen) begin
                        bus.buf_out_arm <= 1'b0;
                        state           <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ep2_cmd_engine.sv
// Bench for ep2_cmd_engine: directed packets for the called-out cases plus
// random packets, each compared against a packet-level reference model.
module tb_ep2_cmd_engine;
    localparam int RD_LAT     = 4;
    localparam int WB_TIMEOUT = 255;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ep2_cmd_engine_if bus();
    logic [7:0]  reset_ctrl;
    logic [1:0]  insel;
    logic [10:0] isoc_commit_len;
    logic [15:0] cmd_count;
    logic [7:0]  err_count;

    ep2_cmd_engine #(.RD_LAT(RD_LAT), .WB_TIMEOUT(WB_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .reset_ctrl(reset_ctrl), .insel(insel), .isoc_commit_len(isoc_commit_len),
        .cmd_count(cmd_count), .err_count(err_count)
    );

    int total = 0;
    int bad   = 0;

    // Packet buffer with RD_LAT cycles of read latency after the address changes
    logic [7:0] pkt_mem [0:511];
    logic [7:0] slave_rd [0:7];
    logic [8:0] apipe [0:RD_LAT-2];
    always @(posedge clk) begin
        apipe[0] <= bus.buf_out_addr;
        for (int i = 1; i < RD_LAT - 1; i++) apipe[i] <= apipe[i-1];
    end
    assign bus.buf_out_q = pkt_mem[apipe[RD_LAT-2]];

    // Environment knobs and observations
    int ack_delay = 1;
    bit ack_stuck = 1'b0;
    int obs_wb_we[$], obs_wb_adr[$], obs_wb_dat[$], obs_stb_len[$];
    int obs_rep_addr[$], obs_rep_data[$], obs_commit_len[$], obs_commit_cyc[$];
    int arm_done = 0, arm_len_last = 0, excl_viol = 0;

    // Reference model state and expectations
    int m_rc, m_insel, m_isoc, m_cmd, m_err;
    int exp_wb_we[$], exp_wb_adr[$], exp_wb_dat[$], exp_stb_len[$], exp_rep[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave/host responders and bus monitor, all on the falling edge
    initial begin
        int stb_cnt, commit_cnt, arm_cyc;
        bit stb_prev, commit_prev, arm_prev;
        stb_cnt = 0; commit_cnt = 0; arm_cyc = 0;
        stb_prev = 0; commit_prev = 0; arm_prev = 0;
        bus.wb_ack_i = 1'b0; bus.wb_dat_i = 8'h00; bus.buf_out_arm_ack = 1'b0;
        bus.usb_in_commit_ack = 1'b0; bus.usb_in_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (((bus.wb_stb_o & bus.usb_in_wren) | (bus.wb_stb_o & bus.usb_in_commit) |
                 (bus.usb_in_wren & bus.usb_in_commit)) === 1'b1) excl_viol++;
            if (bus.wb_stb_o === 1'b1) begin
                if (!stb_prev) begin
                    obs_wb_we.push_back(int'(bus.wb_we_o));
                    obs_wb_adr.push_back(int'(bus.wb_adr_o));
                    obs_wb_dat.push_back(int'(bus.wb_dat_o));
                end
                stb_cnt++;
                bus.wb_ack_i = (!ack_stuck && stb_cnt == ack_delay);
                bus.wb_dat_i = bus.wb_ack_i ? slave_rd[bus.wb_adr_o] : 8'($urandom);
            end else begin
                if (stb_prev) obs_stb_len.push_back(stb_cnt);
                stb_cnt = 0;
                bus.wb_ack_i = 1'b0;
                bus.wb_dat_i = 8'($urandom);
            end
            stb_prev = (bus.wb_stb_o === 1'b1);
            if (bus.usb_in_wren === 1'b1) begin
                obs_rep_addr.push_back(int'(bus.usb_in_addr));
                obs_rep_data.push_back(int'(bus.usb_in_data));
            end
            if (bus.usb_in_commit === 1'b1) begin
                if (!commit_prev) obs_commit_len.push_back(int'(bus.usb_in_commit_len));
                commit_cnt++;
                bus.usb_in_commit_ack = (commit_cnt == 2);
            end else begin
                if (commit_prev) obs_commit_cyc.push_back(commit_cnt);
                commit_cnt = 0;
                bus.usb_in_commit_ack = 1'b0;
            end
            commit_prev = (bus.usb_in_commit === 1'b1);
            bus.usb_in_ready = 1'($urandom_range(0, 1));
            if (bus.buf_out_arm === 1'b1) begin
                arm_cyc++;
                bus.buf_out_arm_ack = (arm_cyc == 2 || arm_cyc == 3);
            end else begin
                if (arm_prev) begin
                    arm_done++;
                    arm_len_last = arm_cyc;
                end
                arm_cyc = 0;
                bus.buf_out_arm_ack = 1'b0;
            end
            arm_prev = (bus.buf_out_arm === 1'b1);
        end
    end

    task automatic model_reset();
        m_rc = 'hF3; m_insel = 0; m_isoc = 512; m_cmd = 0; m_err = 0;
    endtask

    // Whole-packet effect: pairs in order, odd tail dropped
    task automatic model_packet(input int len, input bit stuck);
        int a, d;
        exp_wb_we.delete(); exp_wb_adr.delete(); exp_wb_dat.delete();
        exp_stb_len.delete(); exp_rep.delete();
        for (int k = 0; k < len / 2; k++) begin
            a = int'(pkt_mem[2*k]);
            d = int'(pkt_mem[2*k+1]);
            if (a == 6) m_rc = d;
            else if (a == 7) m_insel = d % 4;
            else if (a == 8) m_isoc = (m_isoc % 256) + (d % 8) * 256;
            else if (a == 9) m_isoc = (m_isoc / 256) * 256 + d;
            else begin
                exp_wb_we.push_back(a == 5 ? 0 : 1);
                exp_wb_adr.push_back(a == 5 ? d % 8 : a % 8);
                exp_wb_dat.push_back(d);
                exp_stb_len.push_back(stuck ? WB_TIMEOUT : ack_delay);
                if (stuck && m_err < 255) m_err++;
                if (a == 5) exp_rep.push_back(stuck ? 'hEE : int'(slave_rd[d % 8]));
            end
            m_cmd = (m_cmd + 1) % 65536;
        end
    endtask

    task automatic clear_obs();
        obs_wb_we.delete(); obs_wb_adr.delete(); obs_wb_dat.delete(); obs_stb_len.delete();
        obs_rep_addr.delete(); obs_rep_data.delete(); obs_commit_len.delete(); obs_commit_cyc.delete();
        excl_viol = 0;
    endtask

    task automatic check_packet(input string name);
        int n;
        chk({name, "/wb_count"}, obs_wb_we.size(), exp_wb_we.size());
        n = (obs_wb_we.size() < exp_wb_we.size()) ? obs_wb_we.size() : exp_wb_we.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s/wb%0d_we", name, i), obs_wb_we[i], exp_wb_we[i]);
            chk($sformatf("%s/wb%0d_adr", name, i), obs_wb_adr[i], exp_wb_adr[i]);
            if (exp_wb_we[i] == 1) chk($sformatf("%s/wb%0d_dat", name, i), obs_wb_dat[i], exp_wb_dat[i]);
            if (i < obs_stb_len.size()) chk($sformatf("%s/wb%0d_stb_len", name, i), obs_stb_len[i], exp_stb_len[i]);
        end
        chk({name, "/reply_count"}, obs_rep_data.size(), exp_rep.size());
        n = (obs_rep_data.size() < exp_rep.size()) ? obs_rep_data.size() : exp_rep.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s/rep%0d_addr", name, i), obs_rep_addr[i], i);
            chk($sformatf("%s/rep%0d_data", name, i), obs_rep_data[i], exp_rep[i]);
        end
        chk({name, "/commits"}, obs_commit_len.size(), (exp_rep.size() > 0) ? 1 : 0);
        if (obs_commit_len.size() > 0 && exp_rep.size() > 0) begin
            chk({name, "/commit_len"}, obs_commit_len[0], exp_rep.size());
            if (obs_commit_cyc.size() > 0) chk({name, "/commit_hold"}, obs_commit_cyc[0], 2);
        end
        chk({name, "/arm_hold"}, arm_len_last, 4);
        chk({name, "/reset_ctrl"}, 32'(reset_ctrl), m_rc);
        chk({name, "/insel"}, 32'(insel), m_insel);
        chk({name, "/isoc"}, 32'(isoc_commit_len), m_isoc);
        chk({name, "/cmd_count"}, 32'(cmd_count), m_cmd);
        chk({name, "/err_count"}, 32'(err_count), m_err);
        chk({name, "/exclusive"}, excl_viol, 0);
    endtask

    task automatic run_packet(input string name, input int len, input int delay, input bit stuck);
        int base, cyc;
        clear_obs();
        ack_delay = delay;
        ack_stuck = stuck;
        model_packet(len, stuck);
        bus.buf_out_len     = 10'(len);
        bus.buf_out_hasdata = 1'b1;
        base = arm_done;
        cyc  = 0;
        while (arm_done == base && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (bus.buf_out_arm === 1'b1) bus.buf_out_hasdata = 1'b0;
        end
        bus.buf_out_hasdata = 1'b0;
        chk({name, "/completed"}, 32'(arm_done != base), 1);
        repeat (2) @(negedge clk);
        check_packet(name);
    endtask

    initial begin
        int cyc, len, sel;
        reset = 1'b1;
        bus.buf_out_hasdata = 1'b0;
        bus.buf_out_len = '0;
        for (int j = 0; j < 8; j++) slave_rd[j] = 8'(j * 17 + 3);
        repeat (3) @(negedge clk);
        chk("rst/stb", 32'(bus.wb_stb_o), 0);
        chk("rst/we", 32'(bus.wb_we_o), 0);
        chk("rst/arm", 32'(bus.buf_out_arm), 0);
        chk("rst/wren", 32'(bus.usb_in_wren), 0);
        chk("rst/commit", 32'(bus.usb_in_commit), 0);
        chk("rst/buf_out_addr", 32'(bus.buf_out_addr), 0);
        chk("rst/usb_in_addr", 32'(bus.usb_in_addr), 0);
        chk("rst/cmd_count", 32'(cmd_count), 0);
        chk("rst/err_count", 32'(err_count), 0);
        chk("rst/reset_ctrl", 32'(reset_ctrl), 'hF3);
        chk("rst/insel", 32'(insel), 0);
        chk("rst/isoc", 32'(isoc_commit_len), 512);
        reset = 1'b0;
        model_reset();
        @(negedge clk);

        // Local register write only
        pkt_mem[0] = 8'h06; pkt_mem[1] = 8'hA5;
        run_packet("reset_ctrl_pkt", 2, 1, 1'b0);

        // One write, one read acked after three cycles
        pkt_mem[0] = 8'h02; pkt_mem[1] = 8'h3C; pkt_mem[2] = 8'h05; pkt_mem[3] = 8'h04;
        slave_rd[4] = 8'h5A;
        run_packet("wr_rd_pkt", 4, 3, 1'b0);

        // Read that never gets acked
        pkt_mem[0] = 8'h05; pkt_mem[1] = 8'h01;
        run_packet("timeout_pkt", 2, 1, 1'b1);

        // isoc length set in two halves; odd tail would change insel if used
        pkt_mem[0] = 8'h08; pkt_mem[1] = 8'h03; pkt_mem[2] = 8'h09; pkt_mem[3] = 8'hFF;
        pkt_mem[4] = 8'h07; pkt_mem[5] = 8'h02;
        run_packet("isoc_odd_pkt", 5, 1, 1'b0);

        // Empty packet
        run_packet("empty_pkt", 0, 1, 1'b0);

        // Reset in the middle of a Wishbone wait
        clear_obs();
        pkt_mem[0] = 8'h05; pkt_mem[1] = 8'h02;
        ack_stuck = 1'b1;
        bus.buf_out_len = 10'd2;
        bus.buf_out_hasdata = 1'b1;
        cyc = 0;
        while (bus.wb_stb_o !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("midreset/stb_seen", 32'(bus.wb_stb_o), 1);
        bus.buf_out_hasdata = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset/stb", 32'(bus.wb_stb_o), 0);
        chk("midreset/reset_ctrl", 32'(reset_ctrl), 'hF3);
        chk("midreset/err_count", 32'(err_count), 0);
        chk("midreset/cmd_count", 32'(cmd_count), 0);
        reset = 1'b0;
        ack_stuck = 1'b0;
        model_reset();
        @(negedge clk);
        pkt_mem[0] = 8'h05; pkt_mem[1] = 8'h04; pkt_mem[2] = 8'h06; pkt_mem[3] = 8'h11;
        run_packet("after_reset_pkt", 4, 2, 1'b0);

        // Random packets
        for (int p = 0; p < 20; p++) begin
            len = $urandom_range(0, 12);
            for (int i = 0; i < len + 1; i++) begin
                if (i % 2 == 0) begin
                    sel = $urandom_range(0, 7);
                    pkt_mem[i] = (sel < 5) ? 8'(sel + 5) : 8'($urandom);
                end else begin
                    pkt_mem[i] = 8'($urandom);
                end
            end
            for (int j = 0; j < 8; j++) slave_rd[j] = 8'($urandom);
            run_packet($sformatf("rnd%0d", p), len, $urandom_range(1, 5), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
